// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC serial front end.
package adc_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    QUIET
  } adc_rx_state_t;

endpackage

// File: rtl/sclk_edge_detect.sv
// Registers the in-domain SCLK and flags its rising and falling edges.
module sclk_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic sclk_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
    end else begin
      sclk_d <= sclk;
    end
  end

  assign sclk_rise = sclk & ~sclk_d;
  assign sclk_fall = ~sclk & sclk_d;

endmodule

// File: rtl/adc_serial_rx.sv
// Frames ADC conversions with chip select, deserialises DOUT and offers
// each 12-bit sample on a valid/ready handshake.
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int FRAME_BITS  = ADC_FRAME_BITS,
  parameter int DATA_BITS   = ADC_DATA_BITS,
  parameter int QUIET_FALLS = 2
) (
  input  logic                 clk_clk,
  input  logic                 reset_n,
  input  logic                 SCLK,
  input  logic                 enable,
  input  logic                 ADC_DOUT,
  output logic                 ADC_CS_N,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 1);
  localparam int QCNT_W = (QUIET_FALLS > 1) ? $clog2(QUIET_FALLS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [QCNT_W-1:0] QUIET_LOAD = QCNT_W'(QUIET_FALLS - 1);

  logic sclk_rise, sclk_fall;

  sclk_edge_detect u_edge (
    .clk       (clk_clk),
    .rst_n     (reset_n),
    .sclk      (SCLK),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // DOUT is launched by the ADC's own clock tree, so it is treated as asynchronous.
  logic dout_meta, dout_s;

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_meta <= 1'b0;
      dout_s    <= 1'b0;
    end else begin
      dout_meta <= ADC_DOUT;
      dout_s    <= dout_meta;
    end
  end

  adc_rx_state_t         state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [QCNT_W-1:0]     qcnt;
  logic [FRAME_BITS-2:0] shreg;
  logic [FRAME_BITS-1:0] shreg_next;
  logic                  accept;

  assign shreg_next = {shreg, dout_s};
  assign accept     = sample_valid & sample_ready;

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ADC_CS_N     <= 1'b1;
      bit_cnt      <= '0;
      qcnt         <= '0;
      shreg        <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // NOTE: within one always_ff the last non-blocking write wins, so a frame
      // completing below overrides this handshake clear in the same cycle.
      if (accept) sample_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (enable && sclk_fall) begin
            ADC_CS_N <= 1'b0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (sclk_rise) begin
            shreg   <= shreg_next[FRAME_BITS-2:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              sample_data  <= shreg_next[DATA_BITS-1:0];
              frame_err    <= |shreg_next[FRAME_BITS-1:DATA_BITS];
              sample_valid <= 1'b1;
              if (sample_valid && !sample_ready) overrun <= 1'b1;
              state <= QUIET;
            end
          end
        end

        QUIET: begin
          // The fall that restarts the next frame counts as the last quiet fall.
          if (!ADC_CS_N) begin
            if (sclk_fall) begin
              ADC_CS_N <= 1'b1;
              qcnt     <= QUIET_LOAD;
            end
          end else if (qcnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (sclk_fall) begin
            qcnt <= qcnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed bench for adc_serial_rx: an ADC model shifts known frames on a
// free-running 24-clock SCLK and the outputs are compared to fixed values.
module tb_adc_serial_rx;

  logic        clk_clk    = 1'b0;
  logic        reset_n    = 1'b0;
  logic        sclk       = 1'b0;
  logic        enable     = 1'b0;
  logic        adc_dout   = 1'b0;
  logic        ready_base = 1'b0;
  logic        sample_ready;
  logic        adc_cs_n;
  logic [11:0] sample_data;
  logic        sample_valid, frame_err, overrun, busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] tx_word      = '0;
  logic [15:0] cur_word     = '0;
  int          bit_idx      = 0;
  int          div          = 0;
  int          frame_rises  = 0;
  logic        cs_prev      = 1'b1;
  logic        collide_arm  = 1'b0;
  logic        rise16_pulse = 1'b0;
  int          valid_cycles  = 0;
  int          cs_low_cycles = 0;
  int          cs_falls      = 0;

  always #5 clk_clk = ~clk_clk;

  assign sample_ready = ready_base | (collide_arm & rise16_pulse);

  adc_serial_rx dut (
    .clk_clk      (clk_clk),
    .reset_n      (reset_n),
    .SCLK         (sclk),
    .enable       (enable),
    .ADC_DOUT     (adc_dout),
    .ADC_CS_N     (adc_cs_n),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  // SCLK generator and ADC model: MSB appears on CS fall, later bits on SCLK falls.
  always @(negedge clk_clk) begin
    rise16_pulse = 1'b0;
    if (adc_cs_n) frame_rises = 0;
    if (cs_prev && !adc_cs_n) begin
      cur_word = tx_word;
      bit_idx  = 15;
      adc_dout = cur_word[15];
      cs_falls++;
    end
    cs_prev = adc_cs_n;
    if (div == 11) begin
      div  = 0;
      sclk = ~sclk;
      if (!adc_cs_n) begin
        if (sclk) begin
          frame_rises++;
          if (frame_rises == 16) rise16_pulse = 1'b1;
        end else if (bit_idx > 0) begin
          bit_idx--;
          adc_dout = cur_word[bit_idx];
        end
      end
    end else begin
      div++;
    end
    if (sample_valid) valid_cycles++;
    if (!adc_cs_n) cs_low_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cs_low();
    for (int i = 0; i < 200 && adc_cs_n; i++) @(negedge clk_clk);
    check("cs_fall_seen", adc_cs_n, 1'b0);
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < 1000 && frame_rises < n; i++) @(negedge clk_clk);
    check("rises_seen", 32'(frame_rises >= n), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk_clk);
    check("return_idle", busy, 1'b0);
  endtask

  task automatic run_frame(input logic [15:0] word, input int drop_rises);
    tx_word = word;
    enable  = 1'b1;
    wait_cs_low();
    check("busy_in_frame", busy, 1'b1);
    wait_rises(drop_rises);
    enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    int falls_snap;

    repeat (3) @(negedge clk_clk);
    check("rst_cs_n", adc_cs_n, 1'b1);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_data", sample_data, 12'h000);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);

    // Nominal frame with the consumer always ready.
    ready_base    = 1'b1;
    valid_cycles  = 0;
    cs_low_cycles = 0;
    run_frame(16'h0ABC, 0);
    check("nom_data", sample_data, 12'hABC);
    check("nom_frame_err", frame_err, 1'b0);
    check("nom_valid_cycles", valid_cycles, 32'd1);
    check("nom_cs_low_cycles", cs_low_cycles, 32'd384);
    check("nom_cs_high", adc_cs_n, 1'b1);

    // Nonzero leading bit, then a clean frame clears the flag.
    run_frame(16'h1ABC, 0);
    check("err_data", sample_data, 12'hABC);
    check("err_frame_err", frame_err, 1'b1);
    run_frame(16'h0123, 0);
    check("clr_data", sample_data, 12'h123);
    check("clr_frame_err", frame_err, 1'b0);

    // Two frames with no consumer.
    ready_base = 1'b0;
    run_frame(16'h0111, 0);
    check("ovr1_valid", sample_valid, 1'b1);
    check("ovr1_data", sample_data, 12'h111);
    check("ovr1_overrun", overrun, 1'b0);
    run_frame(16'h0222, 0);
    check("ovr2_overrun", overrun, 1'b1);
    check("ovr2_data", sample_data, 12'h222);
    check("ovr2_valid", sample_valid, 1'b1);
    ready_base = 1'b1;
    @(negedge clk_clk);
    check("ovr_valid_drop", sample_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // Enable dropped after five bits: frame still delivered, no restart.
    run_frame(16'h0F0F, 5);
    check("en_data", sample_data, 12'hF0F);
    check("en_cs_high", adc_cs_n, 1'b1);
    falls_snap = cs_falls;
    repeat (72) @(negedge clk_clk);
    check("en_no_restart", cs_falls, falls_snap);
    check("en_cs_still_high", adc_cs_n, 1'b1);

    // Reset in the middle of a frame while a sample is pending.
    ready_base = 1'b0;
    run_frame(16'h0777, 0);
    check("pre_rst_valid", sample_valid, 1'b1);
    tx_word = 16'h0999;
    enable  = 1'b1;
    wait_cs_low();
    wait_rises(8);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("mid_rst_cs_n", adc_cs_n, 1'b1);
    check("mid_rst_valid", sample_valid, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_data", sample_data, 12'h000);
    repeat (3) @(negedge clk_clk);
    reset_n    = 1'b1;
    ready_base = 1'b1;
    run_frame(16'h0555, 0);
    check("post_rst_data", sample_data, 12'h555);

    // Handshake accepted in the same clock the next frame completes.
    ready_base = 1'b0;
    run_frame(16'h0AAA, 0);
    check("col_first_valid", sample_valid, 1'b1);
    collide_arm = 1'b1;
    run_frame(16'h0BBB, 0);
    collide_arm = 1'b0;
    check("col_data", sample_data, 12'hBBB);
    check("col_valid", sample_valid, 1'b1);
    check("col_overrun", overrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
